clock_divider_multi: RTL and testbench

//  Parametrised successor to the fixed single-output clock divider. Provides NUM_CH

---
 rtl/clock_divider_multi.sv | 104 ++++++++++
 tb/tb_clock_divider_multi.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/clock_divider_multi.sv
// Multi-channel programmable clock divider: NUM_CH divided clocks and tick strobes
// from one source clock, with per-channel divisors updated through a valid/ready port.
module clock_divider_multi #(
  parameter  int NUM_CH  = 4,
  parameter  int DIV_W   = 16,
  parameter  int DEF_DIV = 2,
  localparam int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              in_clk,
  input  logic              rst_n,
  input  logic [NUM_CH-1:0] ch_en,
  input  logic              sync_restart,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [DIV_W-1:0]  cfg_div,
  output logic [NUM_CH-1:0] out_clk,
  output logic [NUM_CH-1:0] tick
);

  logic [DIV_W-1:0]  r_cnt     [NUM_CH];
  logic [DIV_W-1:0]  r_div_act [NUM_CH];
  logic [DIV_W-1:0]  r_div_shd [NUM_CH];
  logic [NUM_CH-1:0] r_pending;
  logic [NUM_CH-1:0] r_out_clk;
  logic [NUM_CH-1:0] r_tick;

  logic [NUM_CH-1:0] w_accept;
  logic [NUM_CH-1:0] w_run;
  logic [NUM_CH-1:0] w_wrap;

  // Out-of-range channel numbers match no channel, so they stay ready and are dropped.
  always_comb begin
    cfg_ready = rst_n;
    for (int i = 0; i < NUM_CH; i++) begin
      if (cfg_ch == CH_W'(i) && r_pending[i]) cfg_ready = 1'b0;
    end
  end

  always_comb begin
    w_accept = '0;
    w_run    = '0;
    w_wrap   = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      w_accept[i] = cfg_valid && cfg_ready && (cfg_ch == CH_W'(i));
      w_run[i]    = ch_en[i] && (r_div_act[i] != '0);
      // Compare with >= so a divisor lowered while the channel was idle still wraps.
      w_wrap[i]   = w_run[i] && (r_cnt[i] >= r_div_act[i] - DIV_W'(1));
    end
  end

  // NOTE: the per-channel arrays are small control registers, so they are reset
  // explicitly rather than treated as uninitialised storage.
  always_ff @(posedge in_clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        r_cnt[i]     <= '0;
        r_div_act[i] <= DIV_W'(DEF_DIV);
        r_div_shd[i] <= DIV_W'(DEF_DIV);
      end
      r_pending <= '0;
      r_out_clk <= '0;
      r_tick    <= '0;
    end else if (sync_restart) begin
      r_pending <= '0;
      r_out_clk <= '0;
      r_tick    <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        r_cnt[i] <= '0;
        if (w_accept[i]) begin
          r_div_act[i] <= cfg_div;
          r_div_shd[i] <= cfg_div;
        end else if (r_pending[i]) begin
          r_div_act[i] <= r_div_shd[i];
        end
      end
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        r_tick[i] <= 1'b0;
        if (w_wrap[i]) begin
          r_cnt[i]     <= '0;
          r_tick[i]    <= 1'b1;
          r_out_clk[i] <= ~r_out_clk[i];
        end else if (w_run[i]) begin
          r_cnt[i] <= r_cnt[i] + DIV_W'(1);
        end
        if (r_pending[i] && (w_wrap[i] || !ch_en[i] || r_div_act[i] == '0)) begin
          r_div_act[i] <= r_div_shd[i];
          r_pending[i] <= 1'b0;
        end
        // NOTE: non-blocking, so this later assignment wins when an apply and a new
        // accept land in the same cycle; the fresh value stays pending.
        if (w_accept[i]) begin
          r_div_shd[i] <= cfg_div;
          r_pending[i] <= 1'b1;
        end
      end
    end
  end

  assign out_clk = r_out_clk;
  assign tick    = r_tick;

endmodule

// File: tb/tb_clock_divider_multi.sv
// Directed bench for clock_divider_multi: 4-channel instance for the main scenarios,
// plus a 5-channel instance so an out-of-range cfg_ch (5) is representable.
module tb_clock_divider_multi;

  logic        in_clk;
  logic        rst_n;
  logic [3:0]  ch_en;
  logic        sync_restart;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [1:0]  cfg_ch;
  logic [15:0] cfg_div;
  logic [3:0]  out_clk;
  logic [3:0]  tick;

  logic [4:0]  ch_en5;
  logic        sync_restart5;
  logic        cfg_valid5;
  logic        cfg_ready5;
  logic [2:0]  cfg_ch5;
  logic [15:0] cfg_div5;
  logic [4:0]  out_clk5;
  logic [4:0]  tick5;

  int n_vec;
  int n_err;
  int e;

  clock_divider_multi #(.NUM_CH(4), .DIV_W(16), .DEF_DIV(2)) u_dut (
    .in_clk(in_clk), .rst_n(rst_n), .ch_en(ch_en), .sync_restart(sync_restart),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_ch(cfg_ch), .cfg_div(cfg_div),
    .out_clk(out_clk), .tick(tick)
  );

  clock_divider_multi #(.NUM_CH(5), .DIV_W(16), .DEF_DIV(2)) u_dut5 (
    .in_clk(in_clk), .rst_n(rst_n), .ch_en(ch_en5), .sync_restart(sync_restart5),
    .cfg_valid(cfg_valid5), .cfg_ready(cfg_ready5), .cfg_ch(cfg_ch5), .cfg_div(cfg_div5),
    .out_clk(out_clk5), .tick(tick5)
  );

  initial begin
    in_clk = 1'b0;
    forever #5 in_clk = ~in_clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to the falling edge that follows rising edge number 'target'.
  task automatic go(input int target);
    while (e < target) begin
      @(negedge in_clk);
      e++;
    end
  endtask

  initial begin
    n_vec = 0; n_err = 0; e = 0;
    rst_n = 1'b0; ch_en = 4'hF; sync_restart = 1'b0;
    cfg_valid = 1'b0; cfg_ch = 2'd0; cfg_div = 16'd0;
    ch_en5 = 5'h1F; sync_restart5 = 1'b0; cfg_valid5 = 1'b0; cfg_ch5 = 3'd0; cfg_div5 = 16'd0;

    // Reset state
    repeat (2) @(negedge in_clk);
    check("rst_tick", tick, 4'h0);
    check("rst_out", out_clk, 4'h0);
    check("rst_ready", cfg_ready, 1'b0);
    check("rst_ready5", cfg_ready5, 1'b0);
    rst_n = 1'b1;
    #1 check("rel_ready", cfg_ready, 1'b1);

    // Default divisor 2: ticks on even edges, out_clk period 4
    go(1);  check("t1_e1_tick", tick, 4'h0); check("t1_e1_out", out_clk, 4'h0);
    go(2);  check("t1_e2_tick", tick, 4'hF); check("t1_e2_out", out_clk, 4'hF);
    go(3);  check("t1_e3_tick", tick, 4'h0); check("t1_e3_out", out_clk, 4'hF);
    go(4);  check("t1_e4_tick", tick, 4'hF); check("t1_e4_out", out_clk, 4'h0);

    // Ch1 <- 5 while cnt1=1: held pending until the old period ends at edge 8
    go(5);
    cfg_valid = 1'b1; cfg_ch = 2'd1; cfg_div = 16'd5;
    #1 check("t2_ready_pre", cfg_ready, 1'b1);
    go(6);  cfg_valid = 1'b0;
    #1 check("t2_ready_e6", cfg_ready, 1'b0);
    go(7);  check("t2_ready_e7", cfg_ready, 1'b0);
    go(8);  check("t2_ready_e8", cfg_ready, 1'b1);
    check("t2_e8_tick", tick, 4'hF); check("t2_e8_out", out_clk, 4'h0);
    go(12); check("t2_e12_tick", tick, 4'b1101);
    go(13); check("t2_e13_tick", tick, 4'b0010); check("t2_e13_out", out_clk, 4'b0010);
    go(17); check("t2_e17_tick", tick, 4'h0);
    go(18); check("t2_e18_tick", tick, 4'hF); check("t2_e18_out", out_clk, 4'b1101);

    // Ch2 disabled for 7 edges with cnt2=1; one edge remains on resume
    go(19); ch_en = 4'b1011;
    go(20); check("t3_e20_tick", tick, 4'b1001); check("t3_e20_out", out_clk, 4'b0100);
    go(26); check("t3_e26_tick", tick, 4'b1001); check("t3_e26_out", out_clk, 4'b1111);
    ch_en = 4'hF;
    go(27); check("t3_e27_tick", tick, 4'b0100); check("t3_e27_out", out_clk, 4'b1011);
    go(28); check("t3_e28_tick", tick, 4'b1011); check("t3_e28_out", out_clk, 4'b0000);

    // Ch3 <- 0 (applied at wrap, edge 30), then frozen
    cfg_valid = 1'b1; cfg_ch = 2'd3; cfg_div = 16'd0;
    #1 check("t4_ready0", cfg_ready, 1'b1);
    go(29); cfg_valid = 1'b0;
    go(32); check("t4_e32_tick", tick, 4'b0001); check("t4_e32_out", out_clk, 4'b1000);
    go(34); check("t4_e34_tick", tick, 4'b0001); check("t4_e34_out", out_clk, 4'b1111);
    // Ch3 <- 3 while stopped: applied on the next edge, tick three edges later
    cfg_valid = 1'b1; cfg_ch = 2'd3; cfg_div = 16'd3;
    #1 check("t4_ready3", cfg_ready, 1'b1);
    go(35); cfg_valid = 1'b0;
    #1 check("t4_pend_e35", cfg_ready, 1'b0);
    go(36); check("t4_apply_e36", cfg_ready, 1'b1);
    go(38); check("t4_e38_tick", tick, 4'b0011);
    go(39); check("t4_e39_tick", tick, 4'b1100); check("t4_e39_out", out_clk, 4'b0001);

    // sync_restart at mixed phases with same-cycle ch0 <- 7
    sync_restart = 1'b1; cfg_valid = 1'b1; cfg_ch = 2'd0; cfg_div = 16'd7;
    #1 check("t5_ready", cfg_ready, 1'b1);
    go(40); sync_restart = 1'b0; cfg_valid = 1'b0;
    check("t5_e40_tick", tick, 4'h0); check("t5_e40_out", out_clk, 4'h0);
    #1 check("t5_no_pend", cfg_ready, 1'b1);
    go(46); check("t5_e46_tick", tick, 4'b1100);
    go(47); check("t5_e47_tick", tick, 4'b0001); check("t5_e47_out", out_clk, 4'b0111);

    // Reset while ch1 <- 9 is pending: defaults return, pending dropped
    cfg_valid = 1'b1; cfg_ch = 2'd1; cfg_div = 16'd9;
    #1 check("t6_ready_acc", cfg_ready, 1'b1);
    go(48); cfg_valid = 1'b0;
    #1 check("t6_pending", cfg_ready, 1'b0);
    rst_n = 1'b0; cfg_ch = 2'd2;
    #1 check("t6_ready_in_rst", cfg_ready, 1'b0);
    go(49); rst_n = 1'b1; cfg_ch = 2'd1;
    #1 check("t6_pend_cleared", cfg_ready, 1'b1);
    // Out-of-range channel on the 5-channel instance: always ready, write dropped
    cfg_valid5 = 1'b1; cfg_ch5 = 3'd5; cfg_div5 = 16'd7;
    #1 check("t6_oor_ready5", cfg_ready5, 1'b1);
    go(50); check("t6_e50_tick", tick, 4'h0); check("t6_e50_out", out_clk, 4'h0);
    go(51); check("t6_e51_tick", tick, 4'hF); check("t6_e51_out", out_clk, 4'hF);
    check("t6_e51_tick5", tick5, 5'h1F);
    go(52); cfg_ch5 = 3'd7;
    #1 check("t6_oor7_ready5", cfg_ready5, 1'b1);
    go(53); check("t6_e53_tick", tick, 4'hF); check("t6_e53_out", out_clk, 4'h0);
    go(55); check("t6_e55_tick5", tick5, 5'h1F); check("t6_e55_out5", out_clk5, 5'h1F);
    cfg_valid5 = 1'b0;
    go(56); check("t6_e56_tick5", tick5, 5'h00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
